// File: rtl/fetch_insn_buffer_if.sv
// Fetch-to-decode buffer bus: fetch result in, decode handshake out, plus flush/stall/error.
// master = pipeline side (fetch + decode + controller), slave = the buffer.
interface fetch_insn_buffer_if #(
    parameter int AddrWidth = 32,
    parameter int LineWidth = 128,
    parameter int InsnWidth = 32
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_fault;
    logic [AddrWidth-1:0] in_pc;
    logic [LineWidth-1:0] in_line;
    logic                 stall_req;
    logic                 out_valid;
    logic                 out_ready;
    logic [AddrWidth-1:0] out_pc;
    logic [InsnWidth-1:0] out_insn;
    logic                 out_fault;
    logic                 overflow_err;

    modport master (
        output flush, in_valid, in_fault, in_pc, in_line, out_ready,
        input  stall_req, out_valid, out_pc, out_insn, out_fault, overflow_err
    );

    modport slave (
        input  flush, in_valid, in_fault, in_pc, in_line, out_ready,
        output stall_req, out_valid, out_pc, out_insn, out_fault, overflow_err
    );
endinterface

// File: rtl/fetch_insn_buffer.sv
// Fetch-to-decode instruction queue: extracts the pc-selected word at push, show-ahead head.
// Optional zero-latency bypass on an empty buffer: define FETCH_INSN_BUFFER_BYPASS_EN.
module fetch_insn_buffer #(
    parameter int Depth     = 4,
    parameter int LineWidth = 128,
    parameter int AddrWidth = 32,
    parameter int InsnWidth = 32,
    parameter int SkidSlots = 2
) (
    input  logic                clk,
    input  logic                rst,
    fetch_insn_buffer_if.slave  bus
);
    localparam int PtrW     = $clog2(Depth);
    localparam int CntW     = PtrW + 1;
    localparam int NumWords = LineWidth / InsnWidth;
    localparam int WordW    = $clog2(NumWords);
    localparam int ByteW    = $clog2(InsnWidth / 8);
    localparam logic [CntW-1:0] FullLvl  = CntW'(Depth);
    localparam logic [CntW-1:0] StallLvl = CntW'(Depth - SkidSlots);

    typedef struct packed {
        logic [AddrWidth-1:0] pc;
        logic [InsnWidth-1:0] insn;
        logic                 fault;
    } entry_t;

    entry_t          ent_q [Depth];
    entry_t          ent_d [Depth];
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;

    logic [NumWords-1:0][InsnWidth-1:0] line_words;
    logic [WordW-1:0] widx;
    entry_t           in_ent;
    entry_t           head;
    logic             stored_vld, pop, push, bypass, wr;

    assign line_words = bus.in_line;
    assign widx       = bus.in_pc[ByteW +: WordW];

    // A faulting fetch carries no usable line, so the word is forced to zero.
    always_comb begin
        in_ent.pc    = bus.in_pc;
        in_ent.insn  = bus.in_fault ? '0 : line_words[widx];
        in_ent.fault = bus.in_fault;
    end

    assign head       = ent_q[rptr_q];
    assign stored_vld = (count_q != '0);
    assign pop        = stored_vld && bus.out_ready && !bus.flush;
    assign push       = bus.in_valid && !bus.flush && ((count_q < FullLvl) || pop);

`ifdef FETCH_INSN_BUFFER_BYPASS_EN
    assign bypass = !stored_vld && push && bus.out_ready;
`else
    assign bypass = 1'b0;
`endif

    assign wr = push && !bypass;

    always_comb begin
        ent_d   = ent_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (bus.flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (wr) begin
                ent_d[wptr_q] = in_ent;
                wptr_d        = wptr_q + 1'b1;
            end
            if (pop) rptr_d = rptr_q + 1'b1;
            count_d = count_q + CntW'(wr) - CntW'(pop);
            // Sticky until flush/reset: fetch ignored the stall and lost a result.
            if ((count_q == FullLvl) && bus.in_valid && !pop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign bus.stall_req    = (count_q >= StallLvl);
    assign bus.overflow_err = ovf_q;
    assign bus.out_valid    = stored_vld || bypass;
    assign bus.out_pc       = bypass ? in_ent.pc    : head.pc;
    assign bus.out_insn     = bypass ? in_ent.insn  : head.insn;
    assign bus.out_fault    = bypass ? in_ent.fault : head.fault;
endmodule

// File: doc/fetch_insn_buffer.md
Name: fetch_insn_buffer

Overview:
- Decoupling queue between the fetch unit and the decode stage.
- Captures each valid fetch result (pc, full I-cache line, fault flag) and extracts the 32-bit instruction word selected by pc.
- Presents entries in order to decode through a valid/ready handshake.
- Raises a stall request back to fetch early enough to absorb the fetch unit's in-flight cache read.

Parameters:
- Depth, 4, number of buffered entries; power of two, must be >= 4.
- LineWidth, 128, I-cache line width in bits; power of two, >= 64.
- AddrWidth, 32, virtual pc width.
- InsnWidth, 32, instruction width (fixed 4-byte instructions).
- SkidSlots, 2, free slots reserved for in-flight fetch results; must be < Depth.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush (trap, trap return, redirect)
- in_valid  in  1  fetch result valid this cycle
- in_fault  in  1  fetch page fault for in_pc
- in_pc  in  AddrWidth  pc of fetch result
- in_line  in  LineWidth  I-cache line containing in_pc
- stall_req  out  1  request fetch stall (ORed into the fetch stall input by the pipeline controller)
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts head entry
- out_pc  out  AddrWidth  head pc
- out_insn  out  InsnWidth  head instruction
- out_fault  out  1  head fault flag
- overflow_err  out  1  sticky: a result arrived while the buffer was full

Behaviour:
- Reset (rst high at a clock edge):
  - read/write pointers and count cleared to 0; overflow_err cleared to 0.
  - outputs after reset: out_valid=0, stall_req=0, overflow_err=0.
  - out_pc, out_insn and out_fault read storage and are don't-care while out_valid=0.
  - Reset mid-operation discards all entries.
- Word extraction, at push time:
  - word index = in_pc[log2(LineWidth/8)-1:2]; stored insn = in_line[idx*32 +: 32].
  - in_pc[1:0] is ignored.
  - If in_fault=1, stored insn = 0 and out_fault=1 for that entry.
- Storage:
  - circular buffer; pointers are log2(Depth) bits and wrap naturally; count is log2(Depth)+1 bits.
  - out_valid = (count != 0); show-ahead, head fields are driven from the registered head slot.
- Push = in_valid && !flush && (count < Depth || pop).
  - A pushed entry is visible at the outputs at the earliest one cycle later.
- Pop = out_valid && out_ready && !flush.
- Simultaneous push and pop: count is unchanged, both pointers advance; legal even when count == Depth.
- Full (count == Depth) && in_valid && !pop && !flush:
  - the entry is dropped;
  - overflow_err is set on the next edge and stays 1 until rst or flush.
- Empty: pop is impossible; out_ready is ignored.
- stall_req = (count >= Depth - SkidSlots), registered-free combinational from count.
  - Fetch has one registered cache read in flight after stall, so SkidSlots=2 guarantees no overflow in correct operation.
- flush:
  - takes priority over push and pop;
  - next edge: count=0, pointers=0, overflow_err=0;
  - in_valid in the same cycle is discarded.
  - out_valid is 0 in the cycle after the flush.
- Per-entry width: AddrWidth + InsnWidth + 1. The full line is not stored.

Optional Feature:
- Macro: FETCH_INSN_BUFFER_BYPASS_EN.
- Defined: when count == 0 and push && out_ready, the incoming entry is forwarded combinationally:
  - out_valid=1, and out_pc/out_insn/out_fault come from the inputs;
  - the entry is not written and count stays 0;
  - latency is 0 cycles.
  - When count == 0 and out_ready=0, the entry is stored as normal.
- Undefined: no bypass; minimum latency is 1 cycle, and out_valid depends only on count.

Test Plan:
- Reset, then in_valid=1, in_pc=0x8000_0008, in_line word2=0x0000_0013 (others 0xFFFF_FFFF), out_ready=0 -> next cycle out_valid=1, out_pc=0x8000_0008, out_insn=0x0000_0013, out_fault=0.
- Push pcs 0x100, 0x104 with out_ready=0 -> stall_req=1 once count=2; push 0x108, 0x10C -> count=4; push 0x110 -> dropped, overflow_err=1; then out_ready=1 -> 0x100, 0x104, 0x108, 0x10C appear in order.
- Hold count=4, with in_valid=1 and out_ready=1 every cycle for 8 cycles -> no drops, overflow_err=0, pointers wrap and order is preserved.
- Push in_fault=1, in_pc=0x2000 -> out_fault=1, out_insn=0x0000_0000.
- Count=3, flush=1 with in_valid=1 in the same cycle -> next cycle out_valid=0, stall_req=0, incoming entry absent.
- With FETCH_INSN_BUFFER_BYPASS_EN defined, empty buffer, in_valid=1, out_ready=1, in_pc=0x40 -> out_valid=1 in the same cycle with out_pc=0x40, count stays 0. Without the macro -> out_valid=0 that cycle, out_pc=0x40 the next cycle.
